uart_tx_param: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8N1 transmitter in the serial debug/SD-log path. Sends frames with configurable data width, parity and stop bits at a compile-time baud divisor. Takes words through a valid/ready handshake into an optional FIFO, so producers can burst without polling busy. Drives one serial line and sits between the log/command formatter and the board UART pin.

---
 rtl/uart_tx_param.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits) fed through a valid/ready handshake.
// Define UART_TX_PARAM_FIFO_EN to buffer words in a FIFO_DEPTH-entry FIFO;
// otherwise a single holding register is used with identical line timing.
module uart_tx_param #(
   parameter int BAUD_DIV    = 433,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic [DATA_BITS-1:0]          tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   output logic                          uart_tx_o,
   output logic                          uart_busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic [13:0] BAUD_END  = 14'(BAUD_DIV);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

   // Parity bit for a word: odd parity sends ~^data, even parity sends ^data.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      if (PARITY_MODE == 1) begin
         return ~^d;
      end else begin
         return ^d;
      end
   endfunction

   logic                 push_s;
   logic                 pop_s;
   logic                 full_s;
   logic                 empty_s;
   logic [DATA_BITS-1:0] head_s;

   assign push_s     = tx_valid_i & ~full_s;
   assign tx_ready_o = ~full_s;

`ifdef UART_TX_PARAM_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;

   assign full_s       = (level_q == LW'(FIFO_DEPTH));
   assign empty_s      = (level_q == '0);
   assign head_s       = mem_q[rd_ptr_q];
   assign fifo_level_o = level_q;

   // FIFO pointer and level bookkeeping; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO storage write; contents need no reset because the level gates every read.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= tx_data_i;
      end
   end

   // FIFO pointer and level registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
`else
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_vld_q, hold_vld_d;

   assign full_s       = hold_vld_q;
   assign empty_s      = ~hold_vld_q;
   assign head_s       = hold_q;
   assign fifo_level_o = {{(LW-1){1'b0}}, hold_vld_q};

   // Single holding register: a write needs it empty, a pop needs it full.
   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (push_s) begin
         hold_d     = tx_data_i;
         hold_vld_d = 1'b1;
      end else if (pop_s) begin
         hold_vld_d = 1'b0;
      end else begin
         hold_vld_d = hold_vld_q;
      end
   end

   // Holding register state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end
`endif

   logic [2:0]           state_q, state_d;
   logic [13:0]          baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 bit_end_s;

   assign bit_end_s   = (baud_q == BAUD_END);
   assign uart_tx_o   = tx_q;
   assign uart_busy_o = busy_q;

   // Frame sequencer: next line level is computed here so the line output is a plain flop.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      pop_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               shift_d = head_s;
               par_d   = parity_bit(head_s);
               state_d = ST_START;
               baud_d  = 14'd0;
               bit_d   = 4'd0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end else begin
               tx_d   = 1'b1;
               busy_d = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_d = ST_DATA;
               baud_d  = 14'd0;
               bit_d   = 4'd0;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 14'd1;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               baud_d = 14'd0;
               if (bit_q == DATA_LAST) begin
                  bit_d = 4'd0;
                  if (PARITY_MODE != 0) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 14'd1;
            end
         end
         ST_PARITY: begin
            if (bit_end_s) begin
               state_d = ST_STOP;
               baud_d  = 14'd0;
               bit_d   = 4'd0;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + 14'd1;
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               baud_d = 14'd0;
               if (bit_q == STOP_LAST) begin
                  bit_d = 4'd0;
                  if (!empty_s) begin
                     // Chain straight into the next start bit, no idle gap.
                     pop_s   = 1'b1;
                     shift_d = head_s;
                     par_d   = parity_bit(head_s);
                     state_d = ST_START;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                     tx_d    = 1'b1;
                     busy_d  = 1'b0;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
                  tx_d  = 1'b1;
               end
            end else begin
               baud_d = baud_q + 14'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = 14'd0;
            bit_d   = 4'd0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Sequencer registers; reset abandons any partial frame and idles the line high.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         baud_q  <= 14'd0;
         bit_q   <= 4'd0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations share one stimulus stream; each has a
// frame-level reference model (word queue plus per-clock expected line samples).
module tb_uart_tx_param;

   localparam int NCFG = 5;
   localparam int C_BD [NCFG] = '{3, 3, 3, 3, 1};
   localparam int C_DB [NCFG] = '{8, 8, 8, 5, 9};
   localparam int C_PM [NCFG] = '{0, 2, 1, 0, 1};
   localparam int C_SB [NCFG] = '{1, 1, 1, 2, 2};
`ifdef UART_TX_PARAM_FIFO_EN
   localparam int CAP = 16;
`else
   localparam int CAP = 1;
`endif

   logic            clk_s;
   logic            rst_n_s;
   logic [8:0]      data_s;
   logic            valid_s;
   logic [NCFG-1:0] ready_s;
   logic [NCFG-1:0] tx_s;
   logic [NCFG-1:0] busy_s;
   logic [4:0]      level_s [NCFG];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk_s = 1'b0;
   always #5 clk_s = ~clk_s;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int BD = C_BD[g];
      localparam int DB = C_DB[g];
      localparam int PM = C_PM[g];
      localparam int SB = C_SB[g];
      localparam int NB = 1 + DB + ((PM != 0) ? 1 : 0) + SB;

      uart_tx_param #(
         .BAUD_DIV(BD), .DATA_BITS(DB), .PARITY_MODE(PM), .STOP_BITS(SB), .FIFO_DEPTH(16)
      ) dut (
         .clk_i       (clk_s),
         .rst_n_i     (rst_n_s),
         .tx_data_i   (data_s[DB-1:0]),
         .tx_valid_i  (valid_s),
         .tx_ready_o  (ready_s[g]),
         .uart_tx_o   (tx_s[g]),
         .uart_busy_o (busy_s[g]),
         .fifo_level_o(level_s[g])
      );

      int q[$];
      bit line[$];
      int w;
      int ones;
      bit v;
      bit acc;

      // Reference model: stored words in q, expected line value after each future edge in line.
      always @(posedge clk_s or negedge rst_n_s) begin
         if (!rst_n_s) begin
            q.delete();
            line.delete();
         end else begin
            acc = valid_s && (q.size() < CAP);
            if (line.size() > 0) void'(line.pop_front());
            if (line.size() == 0 && q.size() > 0) begin
               w    = q.pop_front();
               ones = $countones(w);
               for (int b = 0; b < NB; b++) begin
                  if (b == 0) v = 1'b0;
                  else if (b <= DB) v = bit'((w >> (b - 1)) & 1);
                  else if (PM != 0 && b == DB + 1) v = (PM == 2) ? bit'(ones % 2) : bit'(1 - ones % 2);
                  else v = 1'b1;
                  repeat (BD + 1) line.push_back(v);
               end
            end
            if (acc) q.push_back(int'(data_s) & ((1 << DB) - 1));
         end
      end

      // Compare process: every cycle out of reset, all outputs against the model.
      always @(negedge clk_s) begin
         if (rst_n_s) begin
            check($sformatf("cfg%0d tx", g), 32'(tx_s[g]), 32'((line.size() > 0) ? line[0] : 1'b1));
            check($sformatf("cfg%0d busy", g), 32'(busy_s[g]), 32'(line.size() > 0));
            check($sformatf("cfg%0d level", g), 32'(level_s[g]), 32'(q.size()));
            check($sformatf("cfg%0d ready", g), 32'(ready_s[g]), 32'(q.size() < CAP));
         end
      end
   end

   logic [63:0] cap [NCFG];
   int          bcnt [NCFG];
   logic [4:0]  lvl0;

   // Write one word to every configuration and record 64 line samples from the next negedge.
   task automatic send_capture(input logic [8:0] d);
      @(negedge clk_s);
      data_s  = d;
      valid_s = 1'b1;
      @(negedge clk_s);
      valid_s = 1'b0;
      for (int g = 0; g < NCFG; g++) bcnt[g] = 0;
      lvl0 = level_s[0];
      for (int i = 0; i < 64; i++) begin
         if (i > 0) @(negedge clk_s);
         for (int g = 0; g < NCFG; g++) begin
            cap[g][i] = tx_s[g];
            bcnt[g] += int'(busy_s[g]);
         end
      end
   endtask

   // Frame bits from captured samples of a BAUD_DIV=3 instance; sample 0 precedes the start bit.
   function automatic logic [31:0] frame_of(input logic [63:0] c, input int nb);
      logic [31:0] f;
      f = 32'd0;
      for (int b = 0; b < nb; b++) f[b] = c[b * 4 + 2];
      return f;
   endfunction

   int n;
   int max_lvl;

   initial begin
      rst_n_s = 1'b1;
      valid_s = 1'b0;
      data_s  = 9'd0;
      #1 rst_n_s = 1'b0;
      repeat (2) @(negedge clk_s);
      for (int g = 0; g < NCFG; g++) begin
         check("reset tx", 32'(tx_s[g]), 32'd1);
         check("reset busy", 32'(busy_s[g]), 32'd0);
         check("reset ready", 32'(ready_s[g]), 32'd1);
         check("reset level", 32'(level_s[g]), 32'd0);
      end
      rst_n_s = 1'b1;

      // 0x55 on every configuration: line pattern and exact busy lengths.
      send_capture(9'h055);
      check("0x55 level after write", 32'(lvl0), 32'd1);
      check("0x55 idle before pop", 32'(cap[0][0]), 32'd1);
      check("0x55 8N1 frame", frame_of(cap[0], 10), 32'h2AA);
      check("0x55 busy 8N1", 32'(bcnt[0]), 32'd40);
      check("0x55 busy 8E1", 32'(bcnt[1]), 32'd44);
      check("0x55 busy 8O1", 32'(bcnt[2]), 32'd44);
      check("0x55 busy 5N2", 32'(bcnt[3]), 32'd32);
      check("0x55 busy 9O2", 32'(bcnt[4]), 32'd26);

      // Parity on 0x07: even sends 1, odd sends 0.
      send_capture(9'h007);
      check("0x07 even frame", frame_of(cap[1], 11), 32'h60E);
      check("0x07 odd frame", frame_of(cap[2], 11), 32'h40E);

      // 0x1F with 5 data bits and 2 stop bits, then idle high.
      send_capture(9'h01F);
      check("0x1F 5N2 frame", frame_of(cap[3], 8), 32'hFE);
      check("0x1F 5N2 idle after", 32'(cap[3][33]), 32'd1);

      // Burst of 20 writes while a frame is on the line: storage fills, extra words dropped.
      @(negedge clk_s);
      data_s  = 9'h0AA;
      valid_s = 1'b1;
      @(negedge clk_s);
      valid_s = 1'b0;
      @(negedge clk_s);
      max_lvl = 0;
      for (int i = 0; i < 20; i++) begin
         data_s  = 9'($urandom_range(0, 511));
         valid_s = 1'b1;
         @(negedge clk_s);
         if (int'(level_s[0]) > max_lvl) max_lvl = int'(level_s[0]);
      end
      valid_s = 1'b0;
      check("burst max level", 32'(max_lvl), 32'(CAP));
      check("burst full ready", 32'(ready_s[0]), 32'd0);
      check("burst full level", 32'(level_s[0]), 32'(CAP));
      repeat (1000) @(negedge clk_s);

      // 0x11 then 0x22 held: 0x22 waits for storage space and chains behind 0x11.
      data_s  = 9'h011;
      valid_s = 1'b1;
      @(negedge clk_s);
      data_s = 9'h022;
      check("hold ready after write", 32'(ready_s[0]), 32'(CAP > 1));
      n = 0;
      while (!ready_s[0] && n < 20) begin
         @(negedge clk_s);
         n++;
      end
      check("hold ready wait", 32'(n), 32'((CAP > 1) ? 0 : 1));
      @(negedge clk_s);
      valid_s = 1'b0;
      repeat (120) @(negedge clk_s);

      // Asynchronous reset in the middle of a data bit.
      data_s  = 9'h0A3;
      valid_s = 1'b1;
      @(negedge clk_s);
      valid_s = 1'b0;
      repeat (10) @(negedge clk_s);
      #2 rst_n_s = 1'b0;
      #1;
      for (int g = 0; g < NCFG; g++) begin
         check("async rst tx", 32'(tx_s[g]), 32'd1);
         check("async rst busy", 32'(busy_s[g]), 32'd0);
         check("async rst level", 32'(level_s[g]), 32'd0);
         check("async rst ready", 32'(ready_s[g]), 32'd1);
      end
      @(negedge clk_s);
      rst_n_s = 1'b1;
      send_capture(9'h03C);
      check("0x3C after reset", frame_of(cap[0], 10), 32'h278);

      // Randomised traffic alternating sparse and dense phases.
      for (int ph = 0; ph < 16; ph++) begin
         for (int i = 0; i < 200; i++) begin
            @(negedge clk_s);
            data_s  = 9'($urandom_range(0, 511));
            valid_s = (ph % 2 == 0) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 0);
         end
      end
      @(negedge clk_s);
      valid_s = 1'b0;
      repeat (1500) @(negedge clk_s);
      for (int g = 0; g < NCFG; g++) begin
         check("drained busy", 32'(busy_s[g]), 32'd0);
         check("drained level", 32'(level_s[g]), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
